// File: rtl/adc_scan_sequencer.sv
// Scans every enabled analog channel: sets the mux address, waits for settling,
// requests an ADC conversion and tags the returned 12-bit sample with its channel.
module adc_scan_sequencer #(
   parameter int unsigned CH_COUNT       = 24,
   parameter int unsigned SETTLE_CYCLES  = 40,
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   parameter logic [31:0] SKIP_MASK      = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        spiReady,
   input  logic [11:0] spiData,
   output logic        dataRequest,
   output logic [2:0]  MxA12,
   output logic [2:0]  MxA3,
   output logic [11:0] chData,
   output logic [4:0]  chAddress,
   output logic        chValid,
   output logic        frameDone,
   output logic        timeoutErr,
   output logic        busy
);

   localparam int unsigned CH_W   = 5;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned SET_W  = 8;
   localparam int unsigned TO_W   = 12;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_REQUEST,
      S_WAIT,
      S_NEXT
   } state_t;

   // Lowest channel below CH_COUNT that is not masked.
   function automatic logic [CH_W-1:0] f_first_ch();
      logic [CH_W-1:0] res;
      logic            found;
      res   = '0;
      found = 1'b0;
      for (int unsigned j = 0; j < 32; j++) begin
         if (!found && (j < CH_COUNT) && !SKIP_MASK[CH_W'(j)]) begin
            res   = CH_W'(j);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Highest channel below CH_COUNT that is not masked.
   function automatic logic [CH_W-1:0] f_last_ch();
      logic [CH_W-1:0] res;
      res = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         if ((j < CH_COUNT) && !SKIP_MASK[CH_W'(j)]) begin
            res = CH_W'(j);
         end
      end
      return res;
   endfunction

   // Next non-masked channel above ch; only used when ch is not the last one.
   function automatic logic [CH_W-1:0] f_next_ch(input logic [CH_W-1:0] ch);
      logic [CH_W-1:0] res;
      logic            found;
      res   = '0;
      found = 1'b0;
      for (int unsigned j = 0; j < 32; j++) begin
         if (!found && (j > 32'(ch)) && (j < CH_COUNT) && !SKIP_MASK[CH_W'(j)]) begin
            res   = CH_W'(j);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   localparam logic [CH_W-1:0] FIRST_CH = f_first_ch();
   localparam logic [CH_W-1:0] LAST_CH  = f_last_ch();

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CH_W-1:0]     r_ch;
   logic [CH_W-1:0]     w_ch_nxt;
   logic                w_wrap;
   logic [SET_W-1:0]    r_settle_cnt;
   logic [TO_W-1:0]     r_to_cnt;
   logic                w_settle_done;
   logic                w_timeout_hit;

   logic                r_data_request, w_data_request;
   logic [2:0]          r_mxa12, w_mxa12;
   logic [2:0]          r_mxa3, w_mxa3;
   logic [DATA_W-1:0]   r_ch_data, w_ch_data;
   logic [CH_W-1:0]     r_ch_address, w_ch_address;
   logic                r_ch_valid, w_ch_valid;
   logic                r_frame_done, w_frame_done;
   logic                r_timeout_err, w_timeout_err;
   logic                r_busy, w_busy;

   assign w_settle_done = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
   assign w_timeout_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and channel selection
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_wrap      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state_nxt = S_SETTLE;
               w_ch_nxt    = FIRST_CH;
            end
         end
         S_SETTLE: begin
            if (w_settle_done) w_state_nxt = S_REQUEST;
         end
         S_REQUEST: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (spiReady || w_timeout_hit) w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            w_wrap = (r_ch == LAST_CH);
            if (w_wrap && !enable) begin
               w_state_nxt = S_IDLE;
               w_ch_nxt    = '0;
            end else begin
               w_state_nxt = S_SETTLE;
               w_ch_nxt    = w_wrap ? FIRST_CH : f_next_ch(r_ch);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; sample wins over timeout in the same cycle
   always_comb begin
      w_data_request = (r_state == S_REQUEST);
      w_ch_valid     = (r_state == S_WAIT) && spiReady;
      w_timeout_err  = (r_state == S_WAIT) && !spiReady && w_timeout_hit;
      w_frame_done   = w_wrap;
      w_busy         = (w_state_nxt != S_IDLE);
      w_mxa12        = r_mxa12;
      w_mxa3         = r_mxa3;
      w_ch_data      = r_ch_data;
      w_ch_address   = r_ch_address;
      if ((w_state_nxt == S_SETTLE) && (r_state != S_SETTLE)) begin
         if (!w_ch_nxt[4]) w_mxa12 = w_ch_nxt[2:0];
         else              w_mxa3  = w_ch_nxt[2:0];
      end
      if (w_ch_valid) begin
         w_ch_data    = spiData;
         w_ch_address = r_ch;
      end
   end

   // Channel, counters and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ch           <= '0;
         r_settle_cnt   <= '0;
         r_to_cnt       <= '0;
         r_data_request <= 1'b0;
         r_mxa12        <= '0;
         r_mxa3         <= '0;
         r_ch_data      <= '0;
         r_ch_address   <= '0;
         r_ch_valid     <= 1'b0;
         r_frame_done   <= 1'b0;
         r_timeout_err  <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_ch           <= w_ch_nxt;
         r_settle_cnt   <= (r_state == S_SETTLE) ? r_settle_cnt + SET_W'(1) : '0;
         r_to_cnt       <= (r_state == S_WAIT) ? r_to_cnt + TO_W'(1) : '0;
         r_data_request <= w_data_request;
         r_mxa12        <= w_mxa12;
         r_mxa3         <= w_mxa3;
         r_ch_data      <= w_ch_data;
         r_ch_address   <= w_ch_address;
         r_ch_valid     <= w_ch_valid;
         r_frame_done   <= w_frame_done;
         r_timeout_err  <= w_timeout_err;
         r_busy         <= w_busy;
      end
   end

   assign dataRequest = r_data_request;
   assign MxA12       = r_mxa12;
   assign MxA3        = r_mxa3;
   assign chData      = r_ch_data;
   assign chAddress   = r_ch_address;
   assign chValid     = r_ch_valid;
   assign frameDone   = r_frame_done;
   assign timeoutErr  = r_timeout_err;
   assign busy        = r_busy;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: full scan, mux mapping, timeout, stop/restart,
// mid-scan reset, plus side instances for a skip mask and a single-channel scan.
module tb_adc_scan_sequencer;

   localparam int SETTLE = 40;
   localparam int TMO    = 100;

   logic        clk = 1'b0;
   logic        reset, enable, spiReady;
   logic [11:0] spiData;
   logic        dataRequest, chValid, frameDone, timeoutErr, busy;
   logic [2:0]  MxA12, MxA3;
   logic [11:0] chData;
   logic [4:0]  chAddress;

   logic        sk_rst_n, sk_en;
   logic        sk_spiReady = 1'b0;
   logic [11:0] sk_spiData  = '0;
   logic        sk_dataRequest, sk_chValid, sk_frameDone, sk_timeoutErr, sk_busy;
   logic [2:0]  sk_MxA12, sk_MxA3;
   logic [11:0] sk_chData;
   logic [4:0]  sk_chAddress;

   logic        one_spiReady = 1'b0;
   logic [11:0] one_spiData  = '0;
   logic        one_dataRequest, one_chValid, one_frameDone, one_timeoutErr, one_busy;
   logic [2:0]  one_MxA12, one_MxA3;
   logic [11:0] one_chData;
   logic [4:0]  one_chAddress;

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int n_req = 0, n_valid = 0, n_frame = 0, n_terr = 0;
   int since_mux = 0;
   bit mux_changed = 1'b0;
   logic [5:0] prev_mux = '0;
   logic [2:0] exp_a12 = '0, exp_a3 = '0;
   int sk_exp = 0, sk_in_frame = 0, sk_frames = 0;
   int one_valids = 0, one_frames = 0;
   bit one_prev_valid = 1'b0;
   int r0, v0, n;

   always #5 clk = ~clk;

   adc_scan_sequencer #(.CH_COUNT(24), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO),
                        .SKIP_MASK(32'h0)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .spiReady(spiReady), .spiData(spiData),
      .dataRequest(dataRequest), .MxA12(MxA12), .MxA3(MxA3), .chData(chData),
      .chAddress(chAddress), .chValid(chValid), .frameDone(frameDone),
      .timeoutErr(timeoutErr), .busy(busy));

   adc_scan_sequencer #(.CH_COUNT(24), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO),
                        .SKIP_MASK(32'h2)) u_skip (
      .clk(clk), .reset(sk_rst_n), .enable(sk_en), .spiReady(sk_spiReady),
      .spiData(sk_spiData), .dataRequest(sk_dataRequest), .MxA12(sk_MxA12), .MxA3(sk_MxA3),
      .chData(sk_chData), .chAddress(sk_chAddress), .chValid(sk_chValid),
      .frameDone(sk_frameDone), .timeoutErr(sk_timeoutErr), .busy(sk_busy));

   adc_scan_sequencer #(.CH_COUNT(1), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TMO),
                        .SKIP_MASK(32'h0)) u_one (
      .clk(clk), .reset(sk_rst_n), .enable(sk_en), .spiReady(one_spiReady),
      .spiData(one_spiData), .dataRequest(one_dataRequest), .MxA12(one_MxA12),
      .MxA3(one_MxA3), .chData(one_chData), .chAddress(one_chAddress),
      .chValid(one_chValid), .frameDone(one_frameDone), .timeoutErr(one_timeoutErr),
      .busy(one_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One negedge sample of the main instance, with event counters and mux-change tracking
   task automatic tick();
      @(negedge clk);
      if (!busy) mux_changed = 1'b0;
      if ({MxA12, MxA3} != prev_mux) begin
         mux_changed = 1'b1;
         since_mux   = 0;
      end else begin
         since_mux++;
      end
      prev_mux = {MxA12, MxA3};
      if (dataRequest) n_req++;
      if (chValid)     n_valid++;
      if (frameDone)   n_frame++;
      if (timeoutErr)  n_terr++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " dataRequest"}, 32'(dataRequest), 32'd0);
      chk({tag, " MxA12"},       32'(MxA12),       32'd0);
      chk({tag, " MxA3"},        32'(MxA3),        32'd0);
      chk({tag, " chData"},      32'(chData),      32'd0);
      chk({tag, " chAddress"},   32'(chAddress),   32'd0);
      chk({tag, " chValid"},     32'(chValid),     32'd0);
      chk({tag, " frameDone"},   32'(frameDone),   32'd0);
      chk({tag, " timeoutErr"},  32'(timeoutErr),  32'd0);
      chk({tag, " busy"},        32'(busy),        32'd0);
   endtask

   // Wait for the conversion request of channel ch and check mux lines and settle time
   task automatic req_phase(input int ch);
      int k;
      k = 0;
      while (dataRequest !== 1'b1 && k < 3000) begin
         tick();
         k++;
      end
      chk($sformatf("request seen ch%0d", ch), 32'(dataRequest), 32'd1);
      if (mux_changed) chk($sformatf("settle latency ch%0d", ch), 32'(since_mux), 32'(SETTLE + 1));
      mux_changed = 1'b0;
      if (ch < 16) exp_a12 = 3'(ch);
      else         exp_a3  = 3'(ch);
      chk($sformatf("MxA12 ch%0d", ch), 32'(MxA12), 32'(exp_a12));
      chk($sformatf("MxA3 ch%0d", ch),  32'(MxA3),  32'(exp_a3));
   endtask

   task automatic do_channel(input int ch, input bit respond);
      int k, vs;
      logic [11:0] d;
      d = 12'h100 + 12'(ch);
      req_phase(ch);
      if (respond) begin
         spiReady = 1'b1;
         spiData  = d;
         tick();
         spiReady = 1'b0;
         spiData  = '0;
         chk($sformatf("chValid ch%0d", ch),   32'(chValid),   32'd1);
         chk($sformatf("chAddress ch%0d", ch), 32'(chAddress), 32'(ch));
         chk($sformatf("chData ch%0d", ch),    32'(chData),    32'(d));
      end else begin
         vs = n_valid;
         k  = 0;
         while (timeoutErr !== 1'b1 && k < 500) begin
            tick();
            k++;
         end
         chk($sformatf("timeout latency ch%0d", ch), 32'(k), 32'(TMO));
         chk($sformatf("no chValid on timeout ch%0d", ch), 32'(n_valid), 32'(vs));
      end
      tick();
      chk($sformatf("frameDone after ch%0d", ch), 32'(frameDone), 32'(ch == 23));
      chk($sformatf("chValid pulse width ch%0d", ch), 32'(chValid), 32'd0);
      chk($sformatf("timeoutErr pulse width ch%0d", ch), 32'(timeoutErr), 32'd0);
   endtask

   // Side instances: auto-responding SPI receivers and sequence monitors
   always @(negedge clk) begin
      if (sk_rst_n) begin
         if (sk_chValid) begin
            chk("skip chAddress", 32'(sk_chAddress), 32'(sk_exp));
            chk("skip chData", 32'(sk_chData), 32'(12'h300 + 12'(sk_exp)));
            sk_in_frame++;
            if (sk_exp == 23)     sk_exp = 0;
            else if (sk_exp == 0) sk_exp = 2;
            else                  sk_exp = sk_exp + 1;
         end
         if (sk_frameDone) begin
            chk("skip samples per frame", 32'(sk_in_frame), 32'd23);
            sk_in_frame = 0;
            sk_frames++;
         end
         sk_spiReady = sk_dataRequest;
         sk_spiData  = 12'h300 + 12'(sk_exp);

         if (one_prev_valid) chk("single-ch frameDone follows chValid", 32'(one_frameDone), 32'd1);
         if (one_chValid) begin
            chk("single-ch chAddress", 32'(one_chAddress), 32'd0);
            one_valids++;
         end
         if (one_frameDone) one_frames++;
         one_prev_valid = one_chValid;
         one_spiReady   = one_dataRequest;
         one_spiData    = 12'h055;
      end
   end

   initial begin
      reset    = 1'b0;
      enable   = 1'b0;
      spiReady = 1'b0;
      spiData  = '0;
      sk_rst_n = 1'b0;
      sk_en    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");

      reset    = 1'b1;
      sk_rst_n = 1'b1;
      repeat (5) tick();
      chk("idle busy with enable low", 32'(busy), 32'd0);
      chk("idle no request", 32'(n_req), 32'd0);

      // Frame 1: every channel answered immediately
      enable = 1'b1;
      sk_en  = 1'b1;
      for (int ch = 0; ch < 24; ch++) do_channel(ch, 1'b1);
      chk("frame1 frameDone count", 32'(n_frame), 32'd1);
      chk("frame1 chValid count", 32'(n_valid), 32'd24);

      // Frame 2: ch 7 never answered, enable dropped after ch 10
      for (int ch = 0; ch < 24; ch++) begin
         do_channel(ch, ch != 7);
         if (ch == 10) enable = 1'b0;
      end
      chk("busy low after final frame", 32'(busy), 32'd0);
      chk("timeoutErr count", 32'(n_terr), 32'd1);
      chk("frame2 chValid count", 32'(n_valid), 32'd47);
      r0 = n_req;
      repeat (200) tick();
      chk("no request while stopped", 32'(n_req), 32'(r0));
      chk("busy stays low while stopped", 32'(busy), 32'd0);
      chk("frameDone count after stop", 32'(n_frame), 32'd2);

      // Frame 3: restart at ch 0, reset during WAIT of ch 12
      enable = 1'b1;
      for (int ch = 0; ch < 12; ch++) do_channel(ch, 1'b1);
      req_phase(12);
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_all_zero("mid-wait reset");
      exp_a12 = '0;
      exp_a3  = '0;
      v0 = n_valid;
      spiReady = 1'b1;
      spiData  = 12'hABC;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      spiReady = 1'b0;
      spiData  = '0;
      repeat (3) tick();
      chk("late spiReady ignored", 32'(n_valid), 32'(v0));
      chk("busy after reset release", 32'(busy), 32'd1);
      do_channel(0, 1'b1);
      do_channel(1, 1'b1);

      n = sk_frames;
      chk("skip instance completed frames", 32'(n >= 3), 32'd1);
      chk("single-ch instance completed frames", 32'(one_frames >= 5), 32'd1);
      chk("single-ch frameDone per chValid", 32'(one_frames), 32'(one_valids));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
